ps2_kbd_ctrl: RTL and testbench

PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

---
 rtl/ps2_kbd_if.sv | 24 ++
 rtl/ps2_kbd_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_if.sv
// PS/2 keyboard controller bus: FIFO pop side (data/ready/nextdata_n) plus the
// key-event stream and status outputs.
interface ps2_kbd_if;
  logic [7:0] data;
  logic       ready;
  logic       nextdata_n;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ev_ext;
  logic [7:0] key_cnt;
  logic       pend;

  modport slave (
    input  data, ready, ev_ready,
    output nextdata_n, ev_valid, ev_code, ev_break, ev_ext, key_cnt, pend
  );

  modport master (
    output data, ready, ev_ready,
    input  nextdata_n, ev_valid, ev_code, ev_break, ev_ext, key_cnt, pend
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code decoder: folds F0/E0 prefixes into key events buffered in a 4-entry queue.
// Optional typematic repeat filter enabled by defining PS2_REPEAT_FILTER_EN.
module ps2_kbd_ctrl #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input logic      clk,
  input logic      rst,
  ps2_kbd_if.slave bus
);
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_DEC  = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic          nextdata_n_r;
  logic [7:0]    byte_r;
  logic          brk_r;
  logic          ext_r;
  logic [TW-1:0] to_cnt_r;
  logic [9:0]    q_mem_r [0:3];
  logic [1:0]    wr_ptr_r;
  logic [1:0]    rd_ptr_r;
  logic [2:0]    count_r;
  logic [7:0]    key_cnt_r;

  logic          is_prefix_s;
  logic          suppress_s;
  logic          push_s;
  logic          pop_s;
  logic          timeout_s;
  logic          pend_s;
  logic [9:0]    head_s;

  // Next-state logic; a pop is only started when the queue has room for its event.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.ready && (count_r < 3'd4)) begin
          state_s = S_POP;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_POP:   state_s = S_DEC;
      S_DEC:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register; nextdata_n is registered from the next state so it is low only in S_POP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      nextdata_n_r <= 1'b1;
    end else begin
      state_r      <= state_s;
      nextdata_n_r <= (state_s != S_POP);
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic       last_vld_r;
  logic [7:0] last_code_r;
  logic       last_ext_r;

  // Last pushed make; a break of that same key forgets it so the next press gets through.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_vld_r  <= 1'b0;
      last_code_r <= 8'h00;
      last_ext_r  <= 1'b0;
    end else if (push_s && !brk_r) begin
      last_vld_r  <= 1'b1;
      last_code_r <= byte_r;
      last_ext_r  <= ext_r;
    end else if (push_s && last_vld_r && (last_code_r == byte_r) && (last_ext_r == ext_r)) begin
      last_vld_r  <= 1'b0;
    end
  end

  assign suppress_s = !brk_r && last_vld_r && (last_code_r == byte_r) && (last_ext_r == ext_r);
`else
  assign suppress_s = 1'b0;
`endif

  assign is_prefix_s = (byte_r == 8'hF0) || (byte_r == 8'hE0);
  assign push_s      = (state_r == S_DEC) && !is_prefix_s && !suppress_s;
  assign pop_s       = (count_r != 3'd0) && bus.ev_ready;
  assign pend_s      = brk_r | ext_r;
  assign timeout_s   = pend_s && (to_cnt_r == TO_LAST);

  // Byte register, loaded during the single pop cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_r <= 8'h00;
    end else if (state_r == S_POP) begin
      byte_r <= bus.data;
    end
  end

  // Prefix flags; a decode in S_DEC wins over a coincident timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      brk_r <= 1'b0;
      ext_r <= 1'b0;
    end else if (state_r == S_DEC) begin
      if (byte_r == 8'hF0) begin
        brk_r <= 1'b1;
      end else if (byte_r == 8'hE0) begin
        ext_r <= 1'b1;
      end else begin
        brk_r <= 1'b0;
        ext_r <= 1'b0;
      end
    end else if (timeout_s) begin
      brk_r <= 1'b0;
      ext_r <= 1'b0;
    end
  end

  // Stale-prefix timer, running only while a prefix is held and no byte is being popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_r <= '0;
    end else if ((state_r == S_POP) || !pend_s || timeout_s) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  // Event queue storage; entries are {break, ext, code}.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_mem_r[wr_ptr_r] <= {brk_r, ext_r, byte_r};
    end
  end

  // Queue pointers, occupancy and make counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r  <= 2'd0;
      rd_ptr_r  <= 2'd0;
      count_r   <= 3'd0;
      key_cnt_r <= 8'h00;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      count_r <= count_r + {2'b00, push_s} - {2'b00, pop_s};
      if (push_s && !brk_r) begin
        key_cnt_r <= key_cnt_r + 8'd1;
      end
    end
  end

  assign head_s         = q_mem_r[rd_ptr_r];
  assign bus.nextdata_n = nextdata_n_r;
  assign bus.ev_valid   = (count_r != 3'd0);
  assign bus.ev_code    = (count_r != 3'd0) ? head_s[7:0] : 8'h00;
  assign bus.ev_break   = (count_r != 3'd0) ? head_s[9]   : 1'b0;
  assign bus.ev_ext     = (count_r != 3'd0) ? head_s[8]   : 1'b0;
  assign bus.key_cnt    = key_cnt_r;
  assign bus.pend       = pend_s;
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: a PS/2 byte FIFO model feeds the DUT and a
// byte-stream reference model predicts the event sequence and make count.
module tb_ps2_kbd_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_kbd_if bus ();

  ps2_kbd_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] ps2_q[$];
  logic [9:0] exp_q[$];
  logic [7:0] exp_keys;
  logic       m_brk;
  logic       m_ext;
`ifdef PS2_REPEAT_FILTER_EN
  logic       m_lv;
  logic [7:0] m_lcode;
  logic       m_lext;
`endif
  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int cyc    = 0;
  int last_pop = -100;
  logic rnd_mode = 1'b0;
  int low_run = 0;

  task automatic drive_fifo();
    bus.ready = (ps2_q.size() != 0);
    bus.data  = (ps2_q.size() != 0) ? ps2_q[0] : 8'h00;
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_keys = 8'h00;
    m_brk = 1'b0;
    m_ext = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
    m_lv = 1'b0;
    m_lcode = 8'h00;
    m_lext = 1'b0;
`endif
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic supp;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      supp = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
      if (!m_brk && m_lv && m_lcode == b && m_lext == m_ext) supp = 1'b1;
      if (!m_brk && !supp) begin
        m_lv = 1'b1; m_lcode = b; m_lext = m_ext;
      end
      if (m_brk && m_lv && m_lcode == b && m_lext == m_ext) m_lv = 1'b0;
`endif
      if (!supp) begin
        exp_q.push_back({m_brk, m_ext, b});
        if (!m_brk) exp_keys = exp_keys + 8'd1;
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    ps2_q.push_back(b);
    model_byte(b);
    drive_fifo();
  endtask

  // One clock: account for the pop/consume the DUT performs at this edge, then advance.
  task automatic tick();
    logic do_pop;
    logic consume;
    do_pop  = (bus.nextdata_n === 1'b0);
    consume = (bus.ev_valid === 1'b1) && (bus.ev_ready === 1'b1);
    if (consume) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %h/%b/%b, required no event", bus.ev_code, bus.ev_break, bus.ev_ext);
      end else begin
        if ({bus.ev_break, bus.ev_ext, bus.ev_code} !== exp_q[0]) begin
          errors++;
          $display("FAIL event: got {brk,ext,code}=%h required %h", {bus.ev_break, bus.ev_ext, bus.ev_code}, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    if (do_pop) begin
      pops++;
      checks++;
      if (ps2_q.size() == 0) begin
        errors++;
        $display("FAIL pop_empty: nextdata_n got 0 required 1 (FIFO empty)");
      end else begin
        void'(ps2_q.pop_front());
      end
      checks++;
      if (cyc - last_pop < 3) begin
        errors++;
        $display("FAIL pop_spacing: got %0d cycles required >= 3", cyc - last_pop);
      end
      last_pop = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    drive_fifo();
    if (rnd_mode) begin
      if (low_run >= 4 || $urandom_range(3) != 0) begin
        bus.ev_ready = 1'b1; low_run = 0;
      end else begin
        bus.ev_ready = 1'b0; low_run++;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((ps2_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: got %0d bytes %0d events left, required 0 0", ps2_q.size(), exp_q.size());
    end
    repeat (4) tick();
    checks++;
    if (bus.ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL extra_event: ev_valid got %b required 0", bus.ev_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ev_ready = 1'b0;
    drive_fifo();
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    model_reset();
    checks += 6;
    if (bus.nextdata_n !== 1'b1) begin errors++; $display("FAIL rst_nextdata_n: got %b required 1", bus.nextdata_n); end
    if (bus.ev_valid !== 1'b0)   begin errors++; $display("FAIL rst_ev_valid: got %b required 0", bus.ev_valid); end
    if ({bus.ev_break, bus.ev_ext, bus.ev_code} !== 10'h000) begin
      errors++; $display("FAIL rst_ev_head: got %h required 000", {bus.ev_break, bus.ev_ext, bus.ev_code});
    end
    if (bus.key_cnt !== 8'h00)   begin errors++; $display("FAIL rst_key_cnt: got %h required 00", bus.key_cnt); end
    if (bus.pend !== 1'b0)       begin errors++; $display("FAIL rst_pend: got %b required 0", bus.pend); end
    if (bus.ready !== 1'b0)      begin errors++; $display("FAIL rst_ready: got %b required 0", bus.ready); end
  endtask

  task automatic test_latency();
    bus.ev_ready = 1'b0;
    send(8'h1C);
    for (int i = 0; i < 20 && bus.nextdata_n !== 1'b0; i++) tick();
    checks++;
    if (bus.nextdata_n !== 1'b0) begin errors++; $display("FAIL lat_pop: nextdata_n got %b required 0", bus.nextdata_n); end
    tick();
    checks++;
    if (bus.ev_valid !== 1'b0) begin errors++; $display("FAIL lat_n1: ev_valid got %b required 0", bus.ev_valid); end
    tick();
    checks += 2;
    if (bus.ev_valid !== 1'b1) begin errors++; $display("FAIL lat_n2: ev_valid got %b required 1", bus.ev_valid); end
    if (bus.ev_code !== 8'h1C) begin errors++; $display("FAIL lat_code: got %h required 1c", bus.ev_code); end
    bus.ev_ready = 1'b1;
    drain(100);
  endtask

  task automatic test_basic();
    int p0;
    p0 = pops;
    bus.ev_ready = 1'b1;
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain(100);
    checks += 2;
    if (pops - p0 != 3) begin errors++; $display("FAIL basic_pops: got %0d required 3", pops - p0); end
    if (bus.key_cnt !== 8'd2) begin errors++; $display("FAIL basic_key_cnt: got %0d required 2", bus.key_cnt); end
  endtask

  task automatic test_repeat();
    logic [7:0] k0;
    int n_make;
    k0 = exp_keys;
`ifdef PS2_REPEAT_FILTER_EN
    n_make = 1;
`else
    n_make = 3;
`endif
    bus.ev_ready = 1'b1;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    checks++;
    if (exp_q.size() != n_make + 1) begin errors++; $display("FAIL repeat_model: got %0d events required %0d", exp_q.size(), n_make + 1); end
    drain(200);
    checks++;
    if (bus.key_cnt !== 8'(k0 + n_make)) begin
      errors++; $display("FAIL repeat_key_cnt: got %0d required %0d", bus.key_cnt, 8'(k0 + n_make));
    end
  endtask

  task automatic test_ext_break();
    bus.ev_ready = 1'b1;
    send(8'hE0);
    drain(50);
    checks++;
    if (bus.pend !== 1'b1) begin errors++; $display("FAIL eb_pend_e0: got %b required 1", bus.pend); end
    send(8'hF0);
    drain(50);
    checks++;
    if (bus.pend !== 1'b1) begin errors++; $display("FAIL eb_pend_f0: got %b required 1", bus.pend); end
    send(8'h75);
    drain(50);
    checks++;
    if (bus.pend !== 1'b0) begin errors++; $display("FAIL eb_pend_code: got %b required 0", bus.pend); end
  endtask

  task automatic test_backpressure();
    int p0;
    logic [7:0] codes [6] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
    p0 = pops;
    bus.ev_ready = 1'b0;
    foreach (codes[i]) send(codes[i]);
    repeat (40) tick();
    checks += 4;
    if (pops - p0 != 4)        begin errors++; $display("FAIL bp_pops: got %0d required 4", pops - p0); end
    if (bus.nextdata_n !== 1'b1) begin errors++; $display("FAIL bp_nextdata_n: got %b required 1", bus.nextdata_n); end
    if (bus.ready !== 1'b1)    begin errors++; $display("FAIL bp_ready: got %b required 1", bus.ready); end
    if (bus.ev_valid !== 1'b1 || bus.ev_code !== 8'h15) begin
      errors++; $display("FAIL bp_head: got %b/%h required 1/15", bus.ev_valid, bus.ev_code);
    end
    bus.ev_ready = 1'b1;
    drain(200);
  endtask

  task automatic test_timeout();
    bus.ev_ready = 1'b1;
    send(8'hF0);
    drain(50);
    repeat (8) tick();
    checks++;
    if (bus.pend !== 1'b1) begin errors++; $display("FAIL to_pend_held: got %b required 1", bus.pend); end
    repeat (12) tick();
    checks++;
    if (bus.pend !== 1'b0) begin errors++; $display("FAIL to_pend_cleared: got %b required 0", bus.pend); end
    m_brk = 1'b0;
    m_ext = 1'b0;
    send(8'h1C);
    drain(50);
  endtask

  task automatic test_random();
    logic [7:0] tbl [6] = '{8'h1C, 8'h1C, 8'h32, 8'h75, 8'h6B, 8'h5A};
    int r;
    rnd_mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(9);
      if (r < 2) send(8'hF0);
      else if (r < 3) send(8'hE0);
      else send(tbl[$urandom_range(5)]);
    end
    send(8'h29);
    drain(5000);
    rnd_mode = 1'b0;
    bus.ev_ready = 1'b1;
    checks++;
    if (bus.key_cnt !== exp_keys) begin errors++; $display("FAIL rnd_key_cnt: got %0d required %0d", bus.key_cnt, exp_keys); end
  endtask

  task automatic test_reset_in_pop();
    bus.ev_ready = 1'b1;
    for (int i = 0; i < 255; i++) send((i % 2 == 0) ? 8'h1C : 8'h32);
    drain(3000);
    checks++;
    if (bus.key_cnt !== exp_keys) begin errors++; $display("FAIL rp_key_cnt_pre: got %0d required %0d", bus.key_cnt, exp_keys); end
    ps2_q.push_back(8'h4B);
    drive_fifo();
    for (int i = 0; i < 20 && bus.nextdata_n !== 1'b0; i++) tick();
    checks++;
    if (bus.nextdata_n !== 1'b0) begin errors++; $display("FAIL rp_pop: nextdata_n got %b required 0", bus.nextdata_n); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    last_pop = -100;
    checks += 4;
    if (bus.nextdata_n !== 1'b1) begin errors++; $display("FAIL rp_nextdata_n: got %b required 1", bus.nextdata_n); end
    if (bus.key_cnt !== 8'h00)   begin errors++; $display("FAIL rp_key_cnt: got %0d required 0", bus.key_cnt); end
    if (bus.ev_valid !== 1'b0)   begin errors++; $display("FAIL rp_ev_valid: got %b required 0", bus.ev_valid); end
    if (bus.pend !== 1'b0)       begin errors++; $display("FAIL rp_pend: got %b required 0", bus.pend); end
    send(8'h1C);
    drain(100);
    checks++;
    if (bus.key_cnt !== 8'd1) begin errors++; $display("FAIL rp_resume: key_cnt got %0d required 1", bus.key_cnt); end
  endtask

  initial begin
    bus.data = 8'h00;
    bus.ready = 1'b0;
    bus.ev_ready = 1'b0;
    test_reset();
    test_latency();
    test_basic();
    test_repeat();
    test_ext_break();
    test_backpressure();
    test_timeout();
    test_random();
    test_reset_in_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
